// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state encoding, default timing constants and the
// registered control-output bundle used by the sequencer.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } sw_state_t;

    // 50 MHz system clock -> 100 Hz centisecond tick, ~5 ms debounce window
    localparam int TICK_DIV_DEF   = 500000;
    localparam int DEB_CYCLES_DEF = 250000;
    localparam int PRE_W_DEF      = 19;
    localparam int DEB_W_DEF      = 18;

    typedef struct packed {
        logic cnt_clr;
        logic disp_freeze;
        logic running;
    } ctrl_t;

    function automatic logic is_counting(input sw_state_t s);
        return (s == RUN) || (s == LAP);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, registered rising-edge pulse.
// Pulse appears DEB_CYCLES+3 edges after first sample; no backpressure, level resets high.
module btn_debounce #(
    parameter int DEB_CYCLES = 250000,
    parameter int DEB_W      = 18
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic             sync0;
    logic             sync1;
    logic             level;
    logic             level_d;
    logic [DEB_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync0   <= 1'b1;
            sync1   <= 1'b1;
            level   <= 1'b1;
            level_d <= 1'b1;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync0   <= btn;
            sync1   <= sync0;
            level_d <= level;
            press   <= level & ~level_d;
            // counter starts on the first differing sample, so the level flips on the
            // (DEB_CYCLES+1)th consecutive differing sample
            if (sync1 == level) begin
                cnt <= '0;
            end else if (cnt == DEB_W'(DEB_CYCLES)) begin
                level <= sync1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: debounced buttons drive IDLE/RUN/PAUSE/LAP FSM and 100 Hz tick prescaler.
// State/controls registered one edge after a press pulse; tick is combinational; no backpressure.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV   = TICK_DIV_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int PRE_W      = PRE_W_DEF,
    parameter int DEB_W      = DEB_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       lap_reset,
    output logic       tick,
    output logic       cnt_clr,
    output logic       disp_freeze,
    output logic       running,
    output logic [1:0] state
);

    sw_state_t        state_q;
    sw_state_t        state_nxt;
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_nxt;
    ctrl_t            ctrl_q;
    ctrl_t            ctrl_nxt;
    logic             ss_pulse;
    logic             lr_pulse;
    logic             pre_wrap;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_ss (
        .clk   (clk),
        .rst   (rst),
        .btn   (start_stop),
        .press (ss_pulse)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_lr (
        .clk   (clk),
        .rst   (rst),
        .btn   (lap_reset),
        .press (lr_pulse)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pre_q   <= '0;
            ctrl_q  <= '{cnt_clr: 1'b1, disp_freeze: 1'b0, running: 1'b0};
        end else begin
            state_q <= state_nxt;
            pre_q   <= pre_nxt;
            ctrl_q  <= ctrl_nxt;
        end
    end

    // start/stop has priority: a simultaneous lap/reset press is dropped
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (ss_pulse) state_nxt = RUN;
            RUN:     if (ss_pulse) state_nxt = PAUSE;
                     else if (lr_pulse) state_nxt = LAP;
            LAP:     if (ss_pulse) state_nxt = PAUSE;
                     else if (lr_pulse) state_nxt = RUN;
            PAUSE:   if (ss_pulse) state_nxt = RUN;
                     else if (lr_pulse) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign pre_wrap = (pre_q == PRE_W'(TICK_DIV - 1));

    // PAUSE keeps the partial interval so resuming does not lose time
    always_comb begin
        pre_nxt = '0;
        if (is_counting(state_q)) begin
            pre_nxt = pre_wrap ? '0 : pre_q + 1'b1;
        end else if (state_q == PAUSE) begin
            pre_nxt = (state_nxt == IDLE) ? '0 : pre_q;
        end
    end

    always_comb begin
        ctrl_nxt             = '0;
        ctrl_nxt.running     = is_counting(state_nxt);
        ctrl_nxt.disp_freeze = (state_nxt == LAP);
        ctrl_nxt.cnt_clr     = lr_pulse && !ss_pulse &&
                               ((state_q == IDLE) || (state_q == PAUSE));
    end

    assign tick        = is_counting(state_q) && pre_wrap;
    assign cnt_clr     = ctrl_q.cnt_clr;
    assign disp_freeze = ctrl_q.disp_freeze;
    assign running     = ctrl_q.running;
    assign state       = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4, DEB_CYCLES=3.
// Button presses take 8 edges: held over edges 0..5, state changes at edge 7.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_stop;
    logic       lap_reset;
    logic       tick;
    logic       cnt_clr;
    logic       disp_freeze;
    logic       running;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    stopwatch_ctrl #(
        .TICK_DIV   (4),
        .DEB_CYCLES (3),
        .PRE_W      (3),
        .DEB_W      (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_stop  (start_stop),
        .lap_reset   (lap_reset),
        .tick        (tick),
        .cnt_clr     (cnt_clr),
        .disp_freeze (disp_freeze),
        .running     (running),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic ss, input logic lr);
        start_stop = ss;
        lap_reset  = lr;
        repeat (6) step();
        start_stop = 1'b0;
        lap_reset  = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        start_stop = 1'b1;
        lap_reset  = 1'b0;
        repeat (2) step();
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
        n_checks++; if (cnt_clr !== 1'b1) begin n_fail++; $display("FAIL reset_cnt_clr got %b want 1", cnt_clr); end
        n_checks++; if (disp_freeze !== 1'b0) begin n_fail++; $display("FAIL reset_freeze got %b want 0", disp_freeze); end
        n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running got %b want 0", running); end
        n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b want 0", tick); end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL held_state cyc %0d got %0d want 0", i, state); end
            n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL held_tick cyc %0d got %b want 0", i, tick); end
            n_checks++; if (cnt_clr !== 1'b0) begin n_fail++; $display("FAIL held_cnt_clr cyc %0d got %b want 0", i, cnt_clr); end
        end
        start_stop = 1'b0;
        repeat (8) step();
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL release_state got %0d want 0", state); end
    endtask

    task automatic test_start();
        press(1'b1, 1'b0);
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL start_state got %0d want 1", state); end
        n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL start_running got %b want 1", running); end
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (tick !== ((i % 4) == 3)) begin
                n_fail++; $display("FAIL start_tick run_cyc %0d got %b want %b", i + 1, tick, (i % 4) == 3);
            end
            step();
        end
    endtask

    task automatic test_pause();
        int tc;
        repeat (3) step();
        press(1'b1, 1'b0);
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL pause_state got %0d want 2", state); end
        n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL pause_running got %b want 0", running); end
        tc = 0;
        repeat (10) begin
            if (tick) tc++;
            step();
        end
        n_checks++; if (tc != 0) begin n_fail++; $display("FAIL pause_ticks got %0d want 0", tc); end
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL pause_hold got %0d want 2", state); end
        press(1'b1, 1'b0);
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL resume_state got %0d want 1", state); end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (tick !== ((i % 4) == 0)) begin
                n_fail++; $display("FAIL resume_tick run_cyc %0d got %b want %b", i + 1, tick, (i % 4) == 0);
            end
            step();
        end
    endtask

    task automatic test_lap();
        int tc;
        press(1'b0, 1'b1);
        n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL lap_state got %0d want 3", state); end
        n_checks++; if (disp_freeze !== 1'b1) begin n_fail++; $display("FAIL lap_freeze got %b want 1", disp_freeze); end
        n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL lap_running got %b want 1", running); end
        tc = 0;
        repeat (8) begin
            if (tick) tc++;
            step();
        end
        n_checks++; if (tc != 2) begin n_fail++; $display("FAIL lap_ticks got %0d want 2", tc); end
        press(1'b0, 1'b1);
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL unlap_state got %0d want 1", state); end
        n_checks++; if (disp_freeze !== 1'b0) begin n_fail++; $display("FAIL unlap_freeze got %b want 0", disp_freeze); end
        repeat (6) step();
    endtask

    task automatic test_clear();
        press(1'b1, 1'b0);
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL clr_pause got %0d want 2", state); end
        repeat (6) step();
        press(1'b0, 1'b1);
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL clr_state got %0d want 0", state); end
        n_checks++; if (cnt_clr !== 1'b1) begin n_fail++; $display("FAIL clr_pulse got %b want 1", cnt_clr); end
        n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL clr_running got %b want 0", running); end
        step();
        n_checks++; if (cnt_clr !== 1'b0) begin n_fail++; $display("FAIL clr_pulse_end got %b want 0", cnt_clr); end
        repeat (5) step();
        press(1'b0, 1'b1);
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL idle_clr_state got %0d want 0", state); end
        n_checks++; if (cnt_clr !== 1'b1) begin n_fail++; $display("FAIL idle_clr_pulse got %b want 1", cnt_clr); end
        step();
        n_checks++; if (cnt_clr !== 1'b0) begin n_fail++; $display("FAIL idle_clr_end got %b want 0", cnt_clr); end
        repeat (5) step();
        press(1'b1, 1'b0);
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL restart_state got %0d want 1", state); end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (tick !== ((i % 4) == 3)) begin
                n_fail++; $display("FAIL restart_tick run_cyc %0d got %b want %b", i + 1, tick, (i % 4) == 3);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        press(1'b1, 1'b1);
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL both_state got %0d want 2", state); end
        n_checks++; if (disp_freeze !== 1'b0) begin n_fail++; $display("FAIL both_freeze got %b want 0", disp_freeze); end
        repeat (6) step();
        press(1'b1, 1'b0);
        repeat (6) step();
        press(1'b0, 1'b1);
        n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL prerst_state got %0d want 3", state); end
        rst = 1'b1;
        step();
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL midrst_state got %0d want 0", state); end
        n_checks++; if (disp_freeze !== 1'b0) begin n_fail++; $display("FAIL midrst_freeze got %b want 0", disp_freeze); end
        n_checks++; if (cnt_clr !== 1'b1) begin n_fail++; $display("FAIL midrst_cnt_clr got %b want 1", cnt_clr); end
        n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL midrst_running got %b want 0", running); end
        n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL midrst_tick got %b want 0", tick); end
        rst = 1'b0;
        step();
        n_checks++; if (cnt_clr !== 1'b0) begin n_fail++; $display("FAIL postrst_cnt_clr got %b want 0", cnt_clr); end
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL postrst_state got %0d want 0", state); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_pause();
        test_lap();
        test_clear();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
